cva5_fifo_structure: RTL and testbench

- Parametrised show-ahead FIFO storage that implements the structure side of the core's FIFO enqueue/dequeue handshake.
- Generalises the fixed-width queue with configurable depth, a flush, occupancy count, an almost-full threshold, and sticky overflow/underflow error flags.
- Sits between producer units (issue, load/store, writeback buffers) and their consumers, and replaces ad-hoc per-unit queues.

---
 rtl/cva5_fifo_structure.sv | 140 ++++++++++++++
 tb/tb_cva5_fifo_structure.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/cva5_fifo_structure.sv
// cva5_fifo_structure
//   Show-ahead FIFO storage used on the structure side of the core's
//   enqueue/dequeue handshake. The depth is configurable. It provides a
//   synchronous flush, an occupancy count, an almost-full threshold, and
//   sticky overflow/underflow error flags.
//
// Ports
//   clk            : core clock, rising-edge
//   rst            : asynchronous active-high reset
//   flush          : synchronous clear of all entries (highest priority)
//   potential_push : early push hint; a push without it is rejected
//   push / data_in : enqueue request and payload
//   pop            : dequeue the head entry
//   data_out       : head entry (valid only when valid=1)
//   valid          : FIFO non-empty
//   full           : count == DEPTH
//   almost_full    : count >= ALMOST_FULL_THRESHOLD
//   count          : current occupancy
//   overflow       : sticky, push refused (full without pop, or no hint)
//   underflow      : sticky, pop attempted while empty
module cva5_fifo_structure #(
  parameter int unsigned DATA_WIDTH            = 42,
  parameter int unsigned DEPTH                 = 4,
  parameter int unsigned ALMOST_FULL_THRESHOLD = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         potential_push,
  input  logic                         push,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         pop,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         valid,
  output logic                         full,
  output logic                         almost_full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(ALMOST_FULL_THRESHOLD);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic                  push_acc, pop_acc;

  // Accepted push/pop. A push needs both the hint and room. When full,
  // room is also available if a pop happens in the same cycle. A pop
  // needs a non-empty FIFO, so push+pop on an empty FIFO only enqueues.
  // Flush discards both.
  always_comb begin
    push_acc = ~flush & push & potential_push & (~full | pop);
    pop_acc  = ~flush & pop & valid;
  end

  generate
    if (DEPTH == 1) begin : g_single
      assign rd_ptr = '0;
      assign wr_ptr = '0;
    end else begin : g_ptrs
      logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
      logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

      // Power-of-two depth: natural pointer overflow is the modulo wrap.
      always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
          rd_ptr_d = '0;
          wr_ptr_d = '0;
        end else begin
          if (pop_acc)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
          if (push_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_ptr_q <= '0;
          wr_ptr_q <= '0;
        end else begin
          rd_ptr_q <= rd_ptr_d;
          wr_ptr_q <= wr_ptr_d;
        end
      end

      assign rd_ptr = rd_ptr_q;
      assign wr_ptr = wr_ptr_q;
    end
  endgenerate

  // Storage is not reset. When full, push+pop writes the old head slot
  // (wr_ptr == rd_ptr) at the same edge that the head advances.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr] <= data_in;
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
    overflow_d  = overflow_q  | (~flush & push & ((full & ~pop) | ~potential_push));
    underflow_d = underflow_q | (~flush & pop & ~valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign data_out    = mem_q[rd_ptr];
  assign valid       = (count_q != '0);
  assign full        = (count_q == FULL_CNT);
  assign almost_full = (count_q >= AF_CNT);
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_cva5_fifo_structure.sv
module tb_cva5_fifo_structure;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=4 instance
  logic       rst4, fl4, pp4, ps4, po4;
  logic [7:0] din4, dout4;
  logic       v4, f4, af4, ov4, un4;
  logic [2:0] cnt4;

  // DEPTH=1 instance
  logic       rst1, fl1, pp1, ps1, po1;
  logic [7:0] din1, dout1;
  logic       v1, f1, af1, ov1, un1;
  logic [0:0] cnt1;

  cva5_fifo_structure #(.DATA_WIDTH(8), .DEPTH(4), .ALMOST_FULL_THRESHOLD(3)) dut4 (
    .clk(clk), .rst(rst4), .flush(fl4), .potential_push(pp4), .push(ps4),
    .data_in(din4), .pop(po4), .data_out(dout4), .valid(v4), .full(f4),
    .almost_full(af4), .count(cnt4), .overflow(ov4), .underflow(un4)
  );

  cva5_fifo_structure #(.DATA_WIDTH(8), .DEPTH(1), .ALMOST_FULL_THRESHOLD(1)) dut1 (
    .clk(clk), .rst(rst1), .flush(fl1), .potential_push(pp1), .push(ps1),
    .data_in(din1), .pop(po1), .data_out(dout1), .valid(v1), .full(f1),
    .almost_full(af1), .count(cnt1), .overflow(ov1), .underflow(un1)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] q4[$];
  logic [7:0] q1[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock for the DEPTH=4 instance. The scoreboard checks the head on
  // every real pop and tracks the expected contents.
  task automatic step4(input logic pp, input logic ps, input logic [7:0] d,
                       input logic po, input logic fl);
    int sz;
    pp4 = pp; ps4 = ps; din4 = d; po4 = po; fl4 = fl;
    if (fl) begin
      q4.delete();
    end else begin
      sz = q4.size();
      if (po && sz > 0) begin
        chk("d4_head", {24'h0, dout4}, {24'h0, q4[0]});
        void'(q4.pop_front());
      end
      if (pp && ps && (sz < 4 || po)) q4.push_back(d);
    end
    @(posedge clk); #1;
    pp4 = 1'b0; ps4 = 1'b0; po4 = 1'b0; fl4 = 1'b0;
    chk("d4_count", {29'h0, cnt4}, q4.size());
    chk("d4_valid", {31'h0, v4}, {31'h0, (q4.size() != 0)});
  endtask

  task automatic step1(input logic ps, input logic [7:0] d, input logic po);
    int sz;
    pp1 = 1'b1; ps1 = ps; din1 = d; po1 = po; fl1 = 1'b0;
    sz = q1.size();
    if (po && sz > 0) begin
      chk("d1_head", {24'h0, dout1}, {24'h0, q1[0]});
      void'(q1.pop_front());
    end
    if (ps && (sz < 1 || po)) q1.push_back(d);
    @(posedge clk); #1;
    ps1 = 1'b0; po1 = 1'b0;
    chk("d1_count", {31'h0, cnt1}, q1.size());
  endtask

  initial begin
    rst4 = 1'b1; fl4 = 0; pp4 = 0; ps4 = 0; po4 = 0; din4 = '0;
    rst1 = 1'b1; fl1 = 0; pp1 = 0; ps1 = 0; po1 = 0; din1 = '0;
    #12;
    chk("rst_count", {29'h0, cnt4}, 0);
    chk("rst_valid", {31'h0, v4}, 0);
    chk("rst_full", {31'h0, f4}, 0);
    chk("rst_af", {31'h0, af4}, 0);
    chk("rst_ovf", {31'h0, ov4}, 0);
    chk("rst_udf", {31'h0, un4}, 0);
    rst4 = 1'b0; rst1 = 1'b0;

    // Fill to full
    step4(1, 1, 8'h11, 0, 0);
    chk("fill1_dout", {24'h0, dout4}, 32'h11);
    chk("fill1_af", {31'h0, af4}, 0);
    step4(1, 1, 8'h22, 0, 0);
    chk("fill2_af", {31'h0, af4}, 0);
    step4(1, 1, 8'h33, 0, 0);
    chk("fill3_af", {31'h0, af4}, 1);
    chk("fill3_full", {31'h0, f4}, 0);
    step4(1, 1, 8'h44, 0, 0);
    chk("fill4_full", {31'h0, f4}, 1);
    chk("fill4_dout", {24'h0, dout4}, 32'h11);
    chk("fill_ovf", {31'h0, ov4}, 0);

    // Push into full without pop: rejected, overflow
    step4(1, 1, 8'h55, 0, 0);
    chk("ovf_count", {29'h0, cnt4}, 4);
    chk("ovf_flag", {31'h0, ov4}, 1);
    // Push+pop on full
    step4(1, 1, 8'h66, 1, 0);
    chk("fullpp_count", {29'h0, cnt4}, 4);
    chk("fullpp_dout", {24'h0, dout4}, 32'h22);
    // Drain: scoreboard expects 22,33,44,66
    for (int i = 0; i < 4; i++) step4(0, 0, 8'h00, 1, 0);
    chk("drain_udf", {31'h0, un4}, 0);

    // Pop on empty
    step4(0, 0, 8'h00, 1, 0);
    chk("udf_flag", {31'h0, un4}, 1);
    // Push+pop on empty: push only
    step4(1, 1, 8'h77, 1, 0);
    chk("emptypp_dout", {24'h0, dout4}, 32'h77);
    chk("emptypp_count", {29'h0, cnt4}, 1);
    step4(0, 0, 8'h00, 1, 0);

    // Wrap-around
    step4(1, 1, 8'hAA, 0, 0);
    chk("preload_dout", {24'h0, dout4}, 32'hAA);
    for (int i = 0; i < 10; i++) step4(1, 1, 8'(i), 1, 0);
    chk("wrap_dout", {24'h0, dout4}, 32'h09);

    // Flush with clean flags
    rst4 = 1'b1; #2;
    chk("async_rst_count", {29'h0, cnt4}, 0);
    rst4 = 1'b0; q4.delete();
    @(posedge clk); #1;
    step4(1, 1, 8'hB1, 0, 0);
    step4(1, 1, 8'hB2, 0, 0);
    step4(1, 1, 8'hB3, 0, 0);
    step4(0, 1, 8'hCC, 1, 1);
    chk("flush_full", {31'h0, f4}, 0);
    chk("flush_ovf", {31'h0, ov4}, 0);
    chk("flush_udf", {31'h0, un4}, 0);
    step4(1, 1, 8'hCD, 1, 1);
    chk("flush_empty_udf", {31'h0, un4}, 0);
    chk("flush_empty_count", {29'h0, cnt4}, 0);
    step4(1, 1, 8'h5A, 0, 0);
    chk("postflush_dout", {24'h0, dout4}, 32'h5A);

    // Push without hint: rejected, overflow
    step4(0, 1, 8'hEE, 0, 0);
    chk("nohint_ovf", {31'h0, ov4}, 1);
    chk("nohint_dout", {24'h0, dout4}, 32'h5A);

    // Mid-cycle async reset
    #2; rst4 = 1'b1; #1;
    chk("midrst_valid", {31'h0, v4}, 0);
    chk("midrst_ovf", {31'h0, ov4}, 0);
    rst4 = 1'b0; q4.delete();

    // DEPTH=1 instance
    @(posedge clk); #1;
    step1(1, 8'h01, 0);
    chk("d1_full", {31'h0, f1}, 1);
    chk("d1_af", {31'h0, af1}, 1);
    chk("d1_dout1", {24'h0, dout1}, 32'h01);
    step1(1, 8'h02, 1);
    chk("d1_dout2", {24'h0, dout1}, 32'h02);
    chk("d1_ovf", {31'h0, ov1}, 0);
    #2; rst1 = 1'b1; #1;
    chk("d1_midrst_valid", {31'h0, v1}, 0);
    chk("d1_midrst_full", {31'h0, f1}, 0);
    rst1 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
